// File: rtl/cv32e40p_tb_mem_arbiter.sv
// cv32e40p_tb_mem_arbiter: N-to-1 OBI request arbiter with an in-order ID FIFO that routes
// downstream responses back to the port that issued them.
module cv32e40p_tb_mem_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_PORTS-1:0]                 m_req_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NUM_PORTS-1:0]                 m_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]    m_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NUM_PORTS-1:0]                 m_gnt_o,
    output logic [NUM_PORTS-1:0]                 m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m_rdata_o,
    output logic                                 s_req_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [DATA_WIDTH/8-1:0]              s_be_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [PW-1:0] r_rr;
    logic [PW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [PW-1:0] w_win;
    logic          w_found, w_push, w_pop;
    int            w_j;

    // Fixed priority is the round-robin search with the start pinned at port 0.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_j = (ARB_MODE == 1) ? i : (int'(r_rr) + i) % NUM_PORTS;
            if (!w_found && m_req_i[w_j]) begin
                w_found = 1'b1;
                w_win   = PW'(w_j);
            end
        end
    end

    // Gating on the registered count keeps a same-cycle pop from re-opening the request path.
    assign s_req_o       = rst_ni & (|m_req_i) & (r_cnt < CW'(MAX_OUTSTANDING));
    assign s_addr_o      = m_addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we_o        = m_we_i[w_win];
    assign s_be_o        = m_be_i[w_win*BW +: BW];
    assign s_wdata_o     = m_wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_push        = s_req_o & s_gnt_i;
    assign w_pop         = s_rvalid_i & (r_cnt != '0);
    assign m_gnt_o       = w_push ? NUM_PORTS'(1) << w_win : '0;
    assign m_rvalid_o    = w_pop ? NUM_PORTS'(1) << r_fifo[r_rd] : '0;
    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = r_cnt;
    assign err_o         = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr  <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) r_fifo[k] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr] <= w_win;
                r_wr         <= (r_wr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr + 1'b1;
                if (ARB_MODE == 0) r_rr <= (w_win == PW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_pop) r_rd <= (r_rd == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd + 1'b1;
            if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
            if (s_rvalid_i && r_cnt == '0) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40p_tb_mem_arbiter.sv
// tb_cv32e40p_tb_mem_arbiter: directed checks of a round-robin and a fixed-priority arbiter
// driven from the same stimulus.
module tb_cv32e40p_tb_mem_arbiter;
    logic        clk, rst_n;
    logic [2:0]  m_req, m_we;
    logic [95:0] m_addr, m_wdata;
    logic [11:0] m_be;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;
    logic [2:0]  gnt0, rv0, gnt1, rv1;
    logic [31:0] rdata0, rdata1, saddr0, saddr1, swdata0, swdata1;
    logic        sreq0, sreq1, swe0, swe1, err0, err1;
    logic [3:0]  sbe0, sbe1;
    logic [1:0]  out0, out1;
    int checks, errors;

    cv32e40p_tb_mem_arbiter #(.ARB_MODE(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(gnt0), .m_rvalid_o(rv0), .m_rdata_o(rdata0),
        .s_req_o(sreq0), .s_addr_o(saddr0), .s_we_o(swe0), .s_be_o(sbe0), .s_wdata_o(swdata0),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .outstanding_o(out0), .err_o(err0));

    cv32e40p_tb_mem_arbiter #(.ARB_MODE(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(gnt1), .m_rvalid_o(rv1), .m_rdata_o(rdata1),
        .s_req_o(sreq1), .s_addr_o(saddr1), .s_we_o(swe1), .s_be_o(sbe1), .s_wdata_o(swdata1),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .outstanding_o(out1), .err_o(err1));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_req = 3'b111; s_gnt = 1'b1; s_rvalid = 1'b1;
        #1;
        checks++; if (sreq0 !== 1'b0) begin errors++; $display("FAIL reset_sreq got %b exp 0", sreq0); end
        checks++; if (sreq1 !== 1'b0) begin errors++; $display("FAIL reset_sreq1 got %b exp 0", sreq1); end
        checks++; if (gnt0 !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt0); end
        checks++; if (rv0 !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", rv0); end
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", out0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        m_req = 3'b010; s_gnt = 1'b1;
        #1;
        checks++; if (sreq0 !== 1'b1) begin errors++; $display("FAIL single_sreq got %b exp 1", sreq0); end
        checks++; if (gnt0 !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", gnt0); end
        checks++; if (saddr0 !== 32'h1000_0100) begin errors++; $display("FAIL single_addr got %h exp 10000100", saddr0); end
        checks++; if (sbe0 !== 4'h3) begin errors++; $display("FAIL single_be got %h exp 3", sbe0); end
        checks++; if (swe0 !== 1'b0) begin errors++; $display("FAIL single_we got %b exp 0", swe0); end
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL single_out0 got %0d exp 0", out0); end
        tick();
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (out0 !== 2'd1) begin errors++; $display("FAIL single_out1 got %0d exp 1", out0); end
        checks++; if (rv0 !== 3'b010) begin errors++; $display("FAIL single_rvalid got %b exp 010", rv0); end
        checks++; if (rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", rdata0); end
        tick();
        idle();
        #1;
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL single_out2 got %0d exp 0", out0); end
        checks++; if (rv0 !== 3'b000) begin errors++; $display("FAIL single_rvalid_end got %b exp 000", rv0); end
    endtask

    task automatic test_round_robin;
        logic [2:0] eg0 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] er0 [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        logic [2:0] er1 [4] = '{3'b000, 3'b001, 3'b001, 3'b001};
        do_reset();
        m_req = 3'b111; s_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_rvalid = (c != 0);
            #1;
            checks++; if (gnt0 !== eg0[c]) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt0, eg0[c]); end
            checks++; if (gnt1 !== 3'b001) begin errors++; $display("FAIL fixed_gnt c%0d got %b exp 001", c, gnt1); end
            checks++; if (rv0 !== er0[c]) begin errors++; $display("FAIL rr_rvalid c%0d got %b exp %b", c, rv0, er0[c]); end
            checks++; if (rv1 !== er1[c]) begin errors++; $display("FAIL fixed_rvalid c%0d got %b exp %b", c, rv1, er1[c]); end
            tick();
        end
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1;
        #1;
        checks++; if (rv0 !== 3'b001) begin errors++; $display("FAIL rr_drain got %b exp 001", rv0); end
        checks++; if (rv1 !== 3'b001) begin errors++; $display("FAIL fixed_drain got %b exp 001", rv1); end
        tick();
        idle();
        #1;
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL rr_out got %0d exp 0", out0); end
        checks++; if (out1 !== 2'd0) begin errors++; $display("FAIL fixed_out got %0d exp 0", out1); end
    endtask

    task automatic test_backpressure;
        do_reset();
        m_req = 3'b001; s_gnt = 1'b1;
        #1;
        checks++; if (gnt0 !== 3'b001) begin errors++; $display("FAIL bp_gnt0 got %b exp 001", gnt0); end
        tick();
        checks++; if (gnt0 !== 3'b001) begin errors++; $display("FAIL bp_gnt1 got %b exp 001", gnt0); end
        checks++; if (out0 !== 2'd1) begin errors++; $display("FAIL bp_out1 got %0d exp 1", out0); end
        tick();
        checks++; if (sreq0 !== 1'b0) begin errors++; $display("FAIL bp_sreq_full got %b exp 0", sreq0); end
        checks++; if (gnt0 !== 3'b000) begin errors++; $display("FAIL bp_gnt_full got %b exp 000", gnt0); end
        checks++; if (out0 !== 2'd2) begin errors++; $display("FAIL bp_out2 got %0d exp 2", out0); end
        s_rvalid = 1'b1;
        #1;
        checks++; if (rv0 !== 3'b001) begin errors++; $display("FAIL bp_rvalid got %b exp 001", rv0); end
        checks++; if (sreq0 !== 1'b0) begin errors++; $display("FAIL bp_sreq_pop got %b exp 0", sreq0); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (out0 !== 2'd1) begin errors++; $display("FAIL bp_out_after got %0d exp 1", out0); end
        checks++; if (sreq0 !== 1'b1) begin errors++; $display("FAIL bp_sreq_again got %b exp 1", sreq0); end
        s_gnt = 1'b0;
        #1;
        checks++; if (gnt0 !== 3'b000) begin errors++; $display("FAIL bp_gnt_held got %b exp 000", gnt0); end
        tick();
        checks++; if (out0 !== 2'd1) begin errors++; $display("FAIL bp_out_held got %0d exp 1", out0); end
        m_req = 3'b000; s_rvalid = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL bp_out_drain got %0d exp 0", out0); end
    endtask

    task automatic test_interleaved;
        do_reset();
        m_req = 3'b001; s_gnt = 1'b1;
        #1;
        checks++; if (gnt0 !== 3'b001) begin errors++; $display("FAIL il_gnt_p0 got %b exp 001", gnt0); end
        tick();
        m_req = 3'b100;
        #1;
        checks++; if (gnt0 !== 3'b100) begin errors++; $display("FAIL il_gnt_p2 got %b exp 100", gnt0); end
        checks++; if (gnt1 !== 3'b100) begin errors++; $display("FAIL il_fixed_gnt_p2 got %b exp 100", gnt1); end
        checks++; if (swdata0 !== 32'hA0A0_0002) begin errors++; $display("FAIL il_wdata got %h exp a0a00002", swdata0); end
        checks++; if (swe0 !== 1'b1) begin errors++; $display("FAIL il_we got %b exp 1", swe0); end
        tick();
        m_req = 3'b000; s_gnt = 1'b0; s_rvalid = 1'b1;
        #1;
        checks++; if (out0 !== 2'd2) begin errors++; $display("FAIL il_out2 got %0d exp 2", out0); end
        checks++; if (rv0 !== 3'b001) begin errors++; $display("FAIL il_rvalid_p0 got %b exp 001", rv0); end
        tick();
        m_req = 3'b010; s_gnt = 1'b1;
        #1;
        checks++; if (gnt0 !== 3'b010) begin errors++; $display("FAIL il_gnt_p1 got %b exp 010", gnt0); end
        checks++; if (rv0 !== 3'b100) begin errors++; $display("FAIL il_rvalid_p2 got %b exp 100", rv0); end
        checks++; if (rv1 !== 3'b100) begin errors++; $display("FAIL il_fixed_rvalid_p2 got %b exp 100", rv1); end
        tick();
        m_req = 3'b000; s_gnt = 1'b0;
        #1;
        checks++; if (out0 !== 2'd1) begin errors++; $display("FAIL il_out_swap got %0d exp 1", out0); end
        checks++; if (rv0 !== 3'b010) begin errors++; $display("FAIL il_rvalid_p1 got %b exp 010", rv0); end
        tick();
        idle();
        #1;
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL il_out_end got %0d exp 0", out0); end
    endtask

    task automatic test_error;
        do_reset();
        s_rvalid = 1'b1;
        #1;
        checks++; if (rv0 !== 3'b000) begin errors++; $display("FAIL err_rvalid got %b exp 000", rv0); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err0); end
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL err_out got %0d exp 0", out0); end
        tick();
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err0); end
        m_req = 3'b001; s_gnt = 1'b1;
        tick();
        tick();
        checks++; if (out0 !== 2'd2) begin errors++; $display("FAIL err_fill got %0d exp 2", out0); end
        rst_n = 1'b0; s_rvalid = 1'b1;
        #1;
        checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL rst_out got %0d exp 0", out0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err0); end
        checks++; if (sreq0 !== 1'b0) begin errors++; $display("FAIL rst_sreq got %b exp 0", sreq0); end
        checks++; if (gnt0 !== 3'b000) begin errors++; $display("FAIL rst_gnt got %b exp 000", gnt0); end
        checks++; if (rv0 !== 3'b000) begin errors++; $display("FAIL rst_rvalid got %b exp 000", rv0); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err1 got %b exp 0", err1); end
        idle();
        tick();
        rst_n = 1'b1; s_rvalid = 1'b1;
        #1;
        checks++; if (rv0 !== 3'b000) begin errors++; $display("FAIL post_rst_rvalid got %b exp 000", rv0); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL post_rst_err got %b exp 1", err0); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0;
        idle();
        for (int p = 0; p < 3; p++) begin
            m_addr[p*32 +: 32]  = 32'h1000_0000 + 32'(p) * 32'h100;
            m_wdata[p*32 +: 32] = 32'hA0A0_0000 + 32'(p);
        end
        m_we = 3'b101;
        m_be = 12'hC3F;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_interleaved();
        test_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
